// File: rtl/fb_port_arbiter.sv
// +------------------------------------------------------------------------+
// | fb_port_arbiter: shares one single-port pixel RAM between VGA scanout  |
// | (priority in the active window) and a req/ack writer port.             |
// | Optional double buffering: define FB_BANK_SWAP_EN.                     |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module fb_port_arbiter #(
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 9,
    parameter int IMG_W     = 80,
    parameter int IMG_H     = 60,
    parameter int HLIM      = 800,
    parameter int VLIM      = 525,
    parameter int STALL_LIM = 1024
) (
    input  logic              clk25,
    input  logic              rst_n,
    input  logic              en,
    input  logic [9:0]        hcount,
    input  logic [9:0]        vcount,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              wr_err,
    output logic              wr_stall,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              swap_req,
    output logic              swap_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam logic [9:0]        C_IMG_W = 10'(IMG_W);
    localparam logic [9:0]        C_IMG_H = 10'(IMG_H);
    localparam logic [9:0]        C_HEND  = 10'(HLIM - 1);
    localparam logic [9:0]        C_VEND  = 10'(VLIM - 1);
    localparam logic [ADDR_W-1:0] C_NPIX  = ADDR_W'(IMG_W * IMG_H);
    localparam int                CNT_W   = $clog2(STALL_LIM + 1);
    localparam logic [CNT_W-1:0]  C_SLIM  = CNT_W'(STALL_LIM);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   disp_addr_q, disp_addr_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic                ram_we_q, ram_we_d;
    logic                wr_ack_q, wr_ack_d;
    logic                wr_err_q, wr_err_d;
    logic                wr_stall_q, wr_stall_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic                rd_v1_q, rd_v1_d;
    logic                rd_v2_q, rd_v2_d;
    logic                pix_valid_q, pix_valid_d;
    logic [DATA_W-1:0]   pix_data_q, pix_data_d;

    logic                w_disp_act;
    logic                w_frame_end;
    logic                w_grant;
    logic                w_wr_oor;
    logic [ADDR_W-1:0]   w_wr_off;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic [ADDR_W-1:0]   w_wr_addr;

    assign w_disp_act  = (state_q == S_RUN) && (hcount < C_IMG_W) && (vcount < C_IMG_H);
    assign w_frame_end = (hcount == C_HEND) && (vcount == C_VEND);
    assign w_grant     = wr_req && !w_disp_act;
    assign w_wr_oor    = (w_wr_off >= C_NPIX);

`ifdef FB_BANK_SWAP_EN
    // Display reads the front bank, the writer fills the back bank.
    logic bank_q, bank_d;
    logic swap_pend_q, swap_pend_d;
    logic swap_done_q, swap_done_d;
    logic w_unused_bank_bits;

    assign w_wr_off  = {1'b0, wr_addr[ADDR_W-2:0]};
    assign w_rd_addr = {bank_q, disp_addr_q[ADDR_W-2:0]};
    assign w_wr_addr = {~bank_q, wr_addr[ADDR_W-2:0]};
    assign w_unused_bank_bits = wr_addr[ADDR_W-1] ^ disp_addr_q[ADDR_W-1];
    assign swap_done = swap_done_q;

    always_comb begin
        swap_pend_d = swap_pend_q | swap_req;
        bank_d      = bank_q;
        swap_done_d = 1'b0;
        if ((state_q == S_RUN) && en && w_frame_end && swap_pend_d) begin
            bank_d      = ~bank_q;
            swap_done_d = 1'b1;
            swap_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            bank_q      <= 1'b0;
            swap_pend_q <= 1'b0;
            swap_done_q <= 1'b0;
        end else begin
            bank_q      <= bank_d;
            swap_pend_q <= swap_pend_d;
            swap_done_q <= swap_done_d;
        end
    end
`else
    logic w_unused_swap;

    assign w_wr_off      = wr_addr;
    assign w_rd_addr     = disp_addr_q;
    assign w_wr_addr     = wr_addr;
    assign w_unused_swap = swap_req;
    assign swap_done     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (en) state_d = S_ARM;
            S_ARM: begin
                if (!en)              state_d = S_IDLE;
                else if (w_frame_end) state_d = S_RUN;
            end
            S_RUN:  if (!en) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        disp_addr_d = disp_addr_q;
        if (w_disp_act && (disp_addr_q < C_NPIX))
            disp_addr_d = disp_addr_q + 1'b1;
        if (w_frame_end || !en)
            disp_addr_d = '0;

        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        wr_ack_d    = 1'b0;
        wr_err_d    = 1'b0;
        if (w_disp_act) begin
            ram_addr_d = w_rd_addr;
        end else if (w_grant) begin
            wr_ack_d = 1'b1;
            if (w_wr_oor) begin
                wr_err_d = 1'b1;
            end else begin
                ram_addr_d  = w_wr_addr;
                ram_wdata_d = wr_data;
                ram_we_d    = 1'b1;
            end
        end

        // Read pipeline: address out, RAM data valid, pixel registered.
        rd_v1_d     = w_disp_act;
        rd_v2_d     = rd_v1_q;
        pix_valid_d = rd_v2_q;
        pix_data_d  = rd_v2_q ? ram_rdata : '0;

        stall_cnt_d = stall_cnt_q;
        wr_stall_d  = wr_stall_q;
        if (w_grant) begin
            stall_cnt_d = '0;
            wr_stall_d  = 1'b0;
        end else if (wr_req) begin
            if (stall_cnt_q != C_SLIM)
                stall_cnt_d = stall_cnt_q + 1'b1;
            if (stall_cnt_d == C_SLIM)
                wr_stall_d = 1'b1;
        end else begin
            stall_cnt_d = '0;
        end
    end

    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            disp_addr_q <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            wr_ack_q    <= 1'b0;
            wr_err_q    <= 1'b0;
            wr_stall_q  <= 1'b0;
            stall_cnt_q <= '0;
            rd_v1_q     <= 1'b0;
            rd_v2_q     <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            disp_addr_q <= disp_addr_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            wr_ack_q    <= wr_ack_d;
            wr_err_q    <= wr_err_d;
            wr_stall_q  <= wr_stall_d;
            stall_cnt_q <= stall_cnt_d;
            rd_v1_q     <= rd_v1_d;
            rd_v2_q     <= rd_v2_d;
            pix_valid_q <= pix_valid_d;
            pix_data_q  <= pix_data_d;
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_we    = ram_we_q;
    assign wr_ack    = wr_ack_q;
    assign wr_err    = wr_err_q;
    assign wr_stall  = wr_stall_q;
    assign pix_valid = pix_valid_q;
    assign pix_data  = pix_data_q;

endmodule

`default_nettype wire

// File: tb/tb_fb_port_arbiter.sv
// +------------------------------------------------------------------------+
// | tb_fb_port_arbiter: scoreboard bench for fb_port_arbiter on a reduced  |
// | frame geometry.  Revision: 1.0                                         |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_fb_port_arbiter;

    localparam int AW = 13;
    localparam int DW = 9;
    localparam int IW = 20;
    localparam int IH = 4;
    localparam int HL = 24;
    localparam int VL = 6;
    localparam int SL = 16;

    logic          clk25 = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [9:0]    hcount = '0;
    logic [9:0]    vcount = '0;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          swap_req = 1'b0;
    logic          wr_ack, wr_err, wr_stall, ram_we, pix_valid, swap_done;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata, pix_data;

    fb_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .IMG_W(IW), .IMG_H(IH),
        .HLIM(HL), .VLIM(VL), .STALL_LIM(SL)
    ) dut (
        .clk25(clk25), .rst_n(rst_n), .en(en),
        .hcount(hcount), .vcount(vcount),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .wr_err(wr_err), .wr_stall(wr_stall),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .pix_data(pix_data), .pix_valid(pix_valid),
        .swap_req(swap_req), .swap_done(swap_done)
    );

    always #5 clk25 = ~clk25;

    int cyc = 0;
    always @(posedge clk25) cyc <= cyc + 1;

    // Synchronous single-port RAM seen by the DUT, plus the bench's own view of its contents.
    logic [DW-1:0] ram     [0:(1<<AW)-1];
    logic [DW-1:0] exp_mem [0:(1<<AW)-1];
    always @(posedge clk25) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    typedef struct { int cyc; logic [DW-1:0] data; } pix_t;
    typedef struct { int cyc; logic [AW-1:0] addr; logic [DW-1:0] data; logic err; } ack_t;
    pix_t pix_q[$];
    ack_t ack_q[$];
    pix_t pe;
    ack_t ae;

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;
    bit done;
    bit run;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_pix(input int h, input int v);
        pix_q.push_back('{cyc: cyc + 3, data: exp_mem[v*IW + h]});
    endtask

    task automatic issue_wr(input int a, input logic [DW-1:0] d, input bit grant);
        logic e;
        wr_req  = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        if (grant) begin
            e = (a >= IW*IH);
            ack_q.push_back('{cyc: cyc + 1, addr: AW'(a), data: d, err: e});
            if (!e) exp_mem[a] = d;
        end
    endtask

    always @(negedge clk25) begin
        if (mon_en) begin
            while (pix_q.size() > 0 && pix_q[0].cyc < cyc) begin
                checks++; failures++;
                $display("FAIL pix_missing: pix_valid=0 at cycle %0d, required 1", pix_q[0].cyc);
                void'(pix_q.pop_front());
            end
            if (pix_valid) begin
                if (pix_q.size() == 0 || pix_q[0].cyc != cyc) begin
                    checks++; failures++;
                    $display("FAIL pix_unexpected at cycle %0d: pix_valid=1, required 0", cyc);
                end else begin
                    pe = pix_q.pop_front();
                    chk("pix_data", 32'(pix_data), 32'(pe.data));
                end
            end else begin
                chk("pix_data_idle", 32'(pix_data), 32'(0));
            end

            while (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
                checks++; failures++;
                $display("FAIL ack_missing: wr_ack=0 at cycle %0d, required 1", ack_q[0].cyc);
                void'(ack_q.pop_front());
            end
            if (wr_ack) begin
                if (ack_q.size() == 0 || ack_q[0].cyc != cyc) begin
                    checks++; failures++;
                    $display("FAIL ack_unexpected at cycle %0d: wr_ack=1, required 0", cyc);
                end else begin
                    ae = ack_q.pop_front();
                    chk("ack_err", 32'(wr_err), 32'(ae.err));
                    chk("ack_we", 32'(ram_we), 32'(!ae.err));
                    if (!ae.err) begin
                        chk("ack_addr", 32'(ram_addr), 32'(ae.addr));
                        chk("ack_wdata", 32'(ram_wdata), 32'(ae.data));
                    end
                end
            end else begin
                chk("we_err_without_ack", 32'({ram_we, wr_err}), 32'(0));
            end
        end
    end

    initial begin
        for (int i = 0; i < (1<<AW); i++) begin
            ram[i]     = DW'(i*37 + 11);
            exp_mem[i] = DW'(i*37 + 11);
        end
        repeat (3) @(posedge clk25);
        #1;
        chk("rst_pix_valid", 32'(pix_valid), 32'(0));
        chk("rst_pix_data",  32'(pix_data),  32'(0));
        chk("rst_wr_ack",    32'(wr_ack),    32'(0));
        chk("rst_wr_err",    32'(wr_err),    32'(0));
        chk("rst_wr_stall",  32'(wr_stall),  32'(0));
        chk("rst_ram_we",    32'(ram_we),    32'(0));
        chk("rst_ram_addr",  32'(ram_addr),  32'(0));
        chk("rst_ram_wdata", 32'(ram_wdata), 32'(0));
        chk("rst_swap_done", 32'(swap_done), 32'(0));
        mon_en = 1'b1;
        done = 1'b0;

        // Frame 0 arms, frames 1 and 3 scan fully, frame 2 drops en mid-frame,
        // frame 4 is cut short by a reset.
        for (int f = 0; f < 5 && !done; f++) begin
            for (int v = 0; v < VL && !done; v++) begin
                for (int h = 0; h < HL && !done; h++) begin
                    hcount = 10'(h);
                    vcount = 10'(v);
                    if (f == 4 && v == 0 && h == 6) begin
                        chk("post_rst_pix_valid", 32'(pix_valid), 32'(0));
                        chk("post_rst_ram_addr",  32'(ram_addr),  32'(0));
                        chk("post_rst_ram_we",    32'(ram_we),    32'(0));
                        rst_n = 1'b1;
                        en    = 1'b0;
                        done  = 1'b1;
                    end else begin
                        en     = !(f == 2 && v == 2 && h >= 10);
                        rst_n  = !(f == 4 && v == 0 && h == 5);
                        wr_req = 1'b0;
                        if (f == 0 && v == 4 && h == 5)  issue_wr(7, 9'h0AA, 1'b1);
                        if (f == 1 && v == 0 && h <= 20) issue_wr(5, 9'h1FF, h == 20);
                        if (f == 1 && v == 1 && h == 22) issue_wr(30, 9'h0F0, 1'b1);
                        if (f == 1 && v == 4 && h == 2)  issue_wr(IW*IH, 9'h155, 1'b1);
                        if (f == 1 && v == 4 && h == 3)  issue_wr(20, 9'h111, 1'b1);
                        if (f == 1 && v == 4 && h == 4)  issue_wr(21, 9'h122, 1'b1);
                        run = (f == 1) || (f == 3) ||
                              (f == 2 && (v < 2 || (v == 2 && h <= 10))) ||
                              (f == 4 && v == 0 && h < 3);
                        if (run && h < IW && v < IH) push_pix(h, v);
                        if (f == 1 && v == 0 && h <= 22)
                            chk("wr_stall", 32'(wr_stall), 32'(h >= 16 && h <= 20));
                        @(posedge clk25);
                        #1;
                    end
                end
            end
        end

        wr_req = 1'b0;
        repeat (6) begin
            @(posedge clk25);
            #1;
        end
        chk("pix_queue_drained", 32'(pix_q.size()), 32'(0));
        chk("ack_queue_drained", 32'(ack_q.size()), 32'(0));
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Shares one single-port pixel RAM (9-bit pixels, 13-bit address) between two users.
- User 1 is the VGA scanout read path, which has absolute priority during the active image window.
- User 2 is a drawing/writer port with a req/ack handshake.
- Sits between the 25 MHz timing generator (hcount/vcount) and the pixel RAM, and feeds registered pixel data to the colour stage.

Parameters:
- ADDR_W, 13, pixel RAM address width.
- DATA_W, 9, pixel width ({b[2:0],g[2:0],r[2:0]} packing).
- IMG_W, 80, image width in pixels, counted in hcount units from hcount=0.
- IMG_H, 60, image height in lines, counted from vcount=0.
- HLIM, 800, total clocks per line.
- VLIM, 525, total lines per frame.
- STALL_LIM, 1024, consecutive unserved writer cycles before wr_stall is raised.

Ports:
- clk25, input, 1, pixel clock; all logic on posedge.
- rst_n, input, 1, reset, synchronous active-low.
- en, input, 1, scanout enable.
- hcount, input, 10, current horizontal count from the timing generator.
- vcount, input, 10, current vertical count from the timing generator.
- wr_req, input, 1, writer request (level).
- wr_addr, input, ADDR_W, writer address.
- wr_data, input, DATA_W, writer data.
- wr_ack, output, 1, one-cycle pulse: transaction consumed.
- wr_err, output, 1, one-cycle pulse with wr_ack: address out of range, write dropped.
- wr_stall, output, 1, sticky starvation flag.
- ram_addr, output, ADDR_W, RAM address (registered).
- ram_we, output, 1, RAM write enable (registered).
- ram_wdata, output, DATA_W, RAM write data (registered).
- ram_rdata, input, DATA_W, RAM read data, valid 1 cycle after ram_addr.
- pix_data, output, DATA_W, scanout pixel (registered).
- pix_valid, output, 1, pix_data is a valid image pixel.
- swap_req, input, 1, bank swap request (FB_BANK_SWAP_EN only).
- swap_done, output, 1, bank swap pulse (FB_BANK_SWAP_EN only).

Behaviour:
- Reset (rst_n=0 at a clk25 edge):
  - All outputs 0; state IDLE; disp_addr=0; stall count=0; bank=0.
  - Reset mid-frame aborts any in-flight read: pix_valid is 0 the cycle after reset.
- Definitions:
  - disp_act = (state==RUN) && hcount<IMG_W && vcount<IMG_H, evaluated on the unregistered inputs.
  - frame_end = hcount==HLIM-1 && vcount==VLIM-1.
- FSM:
  - IDLE: no display reads. Goes to ARM when en=1.
  - ARM: waits for frame_end, then goes to RUN, so display addressing is frame-aligned.
  - RUN: active operation.
  - en=0 in ARM or RUN: go to IDLE the next cycle and clear disp_addr; an in-flight read still completes.
- Display path (latency 3 from the hcount sample):
  - Cycle t, disp_act=1: ram_addr<=disp_addr, ram_we<=0, disp_addr<=disp_addr+1.
  - Cycle t+1: RAM presents data.
  - Cycle t+2: pix_data<=ram_rdata, pix_valid<=1.
  - pix_valid=0 and pix_data=0 for every non-display slot.
  - disp_addr clears to 0 on frame_end and otherwise never exceeds IMG_W*IMG_H.
- Writer path:
  - Served in any cycle where disp_act=0 and wr_req=1; the display slot always wins.
  - Grant: ram_addr<=wr_addr, ram_wdata<=wr_data, ram_we<=1, wr_ack<=1 in the same registered cycle.
  - Back-to-back: wr_req held high after an ack is a new transaction; the writer must present new addr/data the cycle after ack.
  - wr_addr >= IMG_W*IMG_H: wr_ack=1 and wr_err=1, ram_we stays 0.
  - Unserved cycles hold ram_we=0; ram_addr holds its last value.
- Stall counter:
  - Increments each cycle wr_req=1 && no grant; clears on grant or wr_req=0.
  - Saturates at STALL_LIM; on reaching it, wr_stall<=1.
  - wr_stall clears only on the next wr_ack or reset.
- Simultaneous events:
  - frame_end and en falling in the same cycle: IDLE wins.
  - Writes are always allowed in IDLE/ARM, every cycle.

Optional Feature:
- Macro: FB_BANK_SWAP_EN. Enables double buffering.
- Image must fit in 2^(ADDR_W-1) words.
- ram_addr[ADDR_W-1] = bank for display reads and ~bank for writes; writers supply the low ADDR_W-1 bits only, and range checks use those bits.
- swap_req pulse is latched and applied at the next frame_end in RUN: bank toggles and swap_done pulses 1 cycle.
- Second swap_req before apply: merged into the one pending swap.
- Without the macro: full address space, swap_req ignored, swap_done tied 0.

Test Plan:
- Reset release, en=1, run 2 frames → first pix_valid 3 cycles after hcount=0, vcount=0 of frame 2; read addrs 0..4799 in order; 80 pix_valid per line for lines 0..59.
- wr_req held with wr_addr=5, wr_data=9'h1FF at hcount=10, vcount=3 → no ack until hcount=80; ack there with ram_we=1, ram_addr=5; reading back the next frame gives pix_data=9'h1FF at line 0, column 5.
- wr_addr=4800 in blanking → wr_ack=1, wr_err=1, ram_we=0.
- STALL_LIM=16, wr_req forced during the active window only → wr_stall rises after 16 unserved cycles and clears on the first ack at hcount=80.
- en dropped at hcount=40, vcount=20 → IDLE next cycle, pix_valid=0 after the in-flight read; re-enable → no reads until the next frame_end.
- FB_BANK_SWAP_EN: swap_req mid-frame → swap_done at frame_end; next frame reads have ram_addr[12]=1 and writes ram_addr[12]=0.
